// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus arbiter: source indices,
// FU opcode enum, result packet and CDB broadcast types, and the
// default sizing of the age-priority counters.
package cdb_arbiter_pkg;

  localparam int XLEN        = 32;
  localparam int TAG_SIZE    = 6;

  // Result sources; lower index wins under fixed priority.
  localparam int CDB_NUM_SRC  = 5;
  localparam int CDB_SRC_LS    = 0;
  localparam int CDB_SRC_MULT0 = 1;
  localparam int CDB_SRC_MULT1 = 2;
  localparam int CDB_SRC_ALU   = 3;
  localparam int CDB_SRC_BR    = 4;

  // Starvation threshold and counter width for the age-priority build.
  localparam int CDB_AGE_LIMIT = 4;
  localparam int CDB_AGE_W     = 3;

  // Functional-unit identifier carried on the CDB; zero means "no FU".
  typedef enum logic [2:0] {
    NONE_FU  = 3'd0,
    LS_FU    = 3'd1,
    MULT0_FU = 3'd2,
    MULT1_FU = 3'd3,
    ALU_FU   = 3'd4,
    BR_FU    = 3'd5
  } fu_opcode_e;

  // Fields of the execute-stage result that the CDB consumes.
  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic            take_branch;
  } EX_MEM_PACKET;

  // Registered broadcast seen by the RS, ROB and map table.
  typedef struct packed {
    logic                valid;
    logic                clear;
    fu_opcode_e          fu_opcode;
    logic                branch_taken;
    logic [TAG_SIZE-1:0] tag;
    logic [XLEN-1:0]     value;
  } CDB_OUTPUT;

  // Maps a source index to the opcode reported on the bus.
  function automatic fu_opcode_e src_opcode(input int idx);
    case (idx)
      CDB_SRC_LS:    src_opcode = LS_FU;
      CDB_SRC_MULT0: src_opcode = MULT0_FU;
      CDB_SRC_MULT1: src_opcode = MULT1_FU;
      CDB_SRC_ALU:   src_opcode = ALU_FU;
      CDB_SRC_BR:    src_opcode = BR_FU;
      default:       src_opcode = NONE_FU;
    endcase
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle between the functional units (master) and the CDB arbiter
// (slave): per-source valid/ready handshake with tag and result packet,
// the mispredict squash, and the registered broadcast with its grant.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = CDB_NUM_SRC
) ();

  logic                               squash;
  logic [NUM_SRC-1:0]                 src_valid;
  logic [NUM_SRC-1:0][TAG_SIZE-1:0]   src_tag;
  EX_MEM_PACKET [NUM_SRC-1:0]         src_packet;
  logic [NUM_SRC-1:0]                 src_ready;
  logic [NUM_SRC-1:0]                 grant;
  CDB_OUTPUT                          cdb_out;

  // Functional-unit side: offers results, watches ready and the broadcast.
  modport master (
    output squash,
    output src_valid,
    output src_tag,
    output src_packet,
    input  src_ready,
    input  grant,
    input  cdb_out
  );

  // Arbiter side.
  modport slave (
    input  squash,
    input  src_valid,
    input  src_tag,
    input  src_packet,
    output src_ready,
    output grant,
    output cdb_out
  );

endinterface

// File: rtl/cdb_prio_picker.sv
// Combinational fixed-priority picker: returns a one-hot of the lowest
// set bit of req, plus a flag that any request is present.
module cdb_prio_picker #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] pick,
  output logic             any
);

  // Two's-complement trick isolates the lowest set bit (index 0 wins).
  assign pick = req & (~req + WIDTH'(1));
  assign any  = |req;

endmodule

// File: rtl/cdb_arbiter.sv
// Single common data bus arbiter. Each of the five FU result ports owns a
// one-entry hold slot with a valid/ready handshake; one held entry per
// cycle is picked and broadcast on the registered cdb_out.
// Optional feature: define CDB_AGE_PRIO_EN to add per-source age counters
// so an entry that keeps losing eventually beats fixed priority.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = CDB_NUM_SRC,
  parameter int AGE_LIMIT = CDB_AGE_LIMIT,
  parameter int AGE_W     = CDB_AGE_W
) (
  input  logic          clock,
  input  logic          reset,
  cdb_arbiter_if.slave  bus
);

  // Hold slots.
  logic [NUM_SRC-1:0]               hold_valid;
  logic [NUM_SRC-1:0][TAG_SIZE-1:0] hold_tag;
  logic [XLEN-1:0]                  hold_value [NUM_SRC];
  logic [NUM_SRC-1:0]               hold_take;

  // Arbitration.
  logic [NUM_SRC-1:0] base_pick;
  logic               base_any;
  logic [NUM_SRC-1:0] pick;
  logic [NUM_SRC-1:0] ready;
  logic [NUM_SRC-1:0] accept;

  // Broadcast registers.
  CDB_OUTPUT          cdb_next;
  CDB_OUTPUT          cdb_q;
  logic [NUM_SRC-1:0] grant_q;

  cdb_prio_picker #(.WIDTH(NUM_SRC)) u_base_picker (
    .req  (hold_valid),
    .pick (base_pick),
    .any  (base_any)
  );

`ifdef CDB_AGE_PRIO_EN
  logic [AGE_W-1:0]   age [NUM_SRC];
  logic [NUM_SRC-1:0] starved;
  logic [NUM_SRC-1:0] starved_pick;
  logic               starved_any;

  // A held entry that has lost AGE_LIMIT times is starved.
  always_comb begin
    starved = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      starved[i] = hold_valid[i] && (age[i] >= AGE_W'(AGE_LIMIT));
    end
  end

  cdb_prio_picker #(.WIDTH(NUM_SRC)) u_starved_picker (
    .req  (starved),
    .pick (starved_pick),
    .any  (starved_any)
  );

  // Starved sources beat everyone; ties among them fall back to index order.
  assign pick = starved_any ? starved_pick : base_pick;

  // Age counts consecutive losses while held; any slot event restarts it.
  always_ff @(posedge clock) begin
    if (reset || bus.squash) begin
      for (int i = 0; i < NUM_SRC; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (accept[i] || pick[i]) begin
          age[i] <= '0;
        end else if (hold_valid[i] && (age[i] < AGE_W'(AGE_LIMIT))) begin
          age[i] <= age[i] + AGE_W'(1);
        end
      end
    end
  end
`else
  assign pick = base_pick;
`endif

  // A slot is free when empty or when its entry leaves this cycle; squash
  // opens every slot so stalled FUs drain their (dropped) results.
  assign ready  = bus.squash ? '1 : (~hold_valid | pick);
  assign accept = bus.src_valid & ready & {NUM_SRC{~bus.squash}};

  // Build the broadcast for the picked slot; an idle bus is all zeros.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    cdb_next = '0;
    if (base_any) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (pick[i]) begin
          cdb_next.valid        = 1'b1;
          cdb_next.clear        = 1'b1;
          cdb_next.fu_opcode    = src_opcode(i);
          cdb_next.branch_taken = hold_take[i] && (i == CDB_SRC_BR);
          cdb_next.tag          = hold_tag[i];
          cdb_next.value        = hold_value[i];
        end
      end
    end
  end

  // Slot occupancy and broadcast registers; reset dominates squash.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || bus.squash) begin
      hold_valid <= '0;
      grant_q    <= '0;
      cdb_q      <= '0;
    end else begin
      hold_valid <= (hold_valid & ~pick) | accept;
      grant_q    <= pick;
      cdb_q      <= cdb_next;
    end
  end

  // Payload capture on every accepted transfer.
  // NOTE: payload storage has no reset; hold_valid alone qualifies its contents.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (accept[i]) begin
        hold_tag[i]   <= bus.src_tag[i];
        hold_value[i] <= bus.src_packet[i].alu_result;
        hold_take[i]  <= bus.src_packet[i].take_branch;
      end
    end
  end

  assign bus.src_ready = ready;
  assign bus.grant     = grant_q;
  assign bus.cdb_out   = cdb_q;

endmodule
